// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order response tracking and a decode FIFO.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module inst_fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_WIDTH-1:0]      pc_i,
  input  logic                     flush,
  output logic                     fetch_stall,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [INST_WIDTH-1:0]    imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [INST_WIDTH-1:0]    inst_data,
  output logic [PC_WIDTH-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0]   ifq_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = CW + 1;

  logic [PC_WIDTH-1:0]   addrMem_q [MAX_OUT];
  logic [AW-1:0]         aWr_q, aRd_q;
  logic [OW-1:0]         out_q, drop_q, drop_d;
  logic [PC_WIDTH-1:0]   pcMem_q [DEPTH];
  logic [INST_WIDTH-1:0] instMem_q [DEPTH];
  logic [IW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q;

  logic [SW-1:0] creditSum;
  logic          accept, resp, keep, push, pop, headValid, bypass;

  always_comb begin
    creditSum   = SW'(count_q) + SW'(out_q);
    imem_req    = rst_n && !flush && (out_q < OW'(MAX_OUT)) && (creditSum < SW'(DEPTH));
    accept      = imem_req && imem_gnt;
    fetch_stall = !accept;
    imem_addr   = pc_i;
    // A response with nothing outstanding is a leftover from before reset
    resp        = imem_rvalid && (out_q != '0);
    keep        = resp && (drop_q == '0) && !flush;
    headValid   = (count_q != '0);
    pop         = headValid && inst_ready && !flush;
`ifdef IFQ_BYPASS_EN
    bypass      = keep && !headValid;
    push        = keep && !(bypass && inst_ready);
    inst_valid  = headValid || bypass;
    inst_data   = bypass ? imem_rdata : instMem_q[rd_q];
    inst_pc     = bypass ? addrMem_q[aRd_q] : pcMem_q[rd_q];
`else
    bypass      = 1'b0;
    push        = keep;
    inst_valid  = headValid;
    inst_data   = instMem_q[rd_q];
    inst_pc     = pcMem_q[rd_q];
`endif
    ifq_count   = count_q;
    // Everything still in flight once the flush cycle ends must be discarded
    if (flush)
      drop_d = out_q - OW'(resp);
    else if (resp && (drop_q != '0))
      drop_d = drop_q - OW'(1);
    else
      drop_d = drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) addrMem_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem_q[i]   <= '0;
        instMem_q[i] <= '0;
      end
      aWr_q   <= '0;
      aRd_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        addrMem_q[aWr_q] <= pc_i;
        aWr_q <= (aWr_q == AW'(MAX_OUT - 1)) ? '0 : aWr_q + AW'(1);
      end
      if (resp)
        aRd_q <= (aRd_q == AW'(MAX_OUT - 1)) ? '0 : aRd_q + AW'(1);
      out_q  <= out_q + OW'(accept) - OW'(resp);
      drop_q <= drop_d;
      if (flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          pcMem_q[wr_q]   <= addrMem_q[aRd_q];
          instMem_q[wr_q] <= imem_rdata;
          wr_q            <= wr_q + IW'(1);
        end
        if (pop)
          rd_q <= rd_q + IW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a memory model answers fetches in order and every
// accepted fetch is expected at decode as {pc, word} unless a flush or reset discards it.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, imem_gnt, imem_rvalid, inst_ready;
  logic [31:0] pc_i, imem_rdata;
  logic        fetch_stall, imem_req, inst_valid;
  logic [31:0] imem_addr, inst_data, inst_pc;
  logic [2:0]  ifq_count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .flush(flush), .fetch_stall(fetch_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .ifq_count(ifq_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int cyc = 0;
  logic        rstV, gntV, readyV, flushV, respEn, autoPc;
  logic [31:0] pcReg;
  logic [31:0] pendA[$];
  int          pendC[$];
  logic [63:0] sb[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: apply inputs at negedge, then observe this cycle's handshakes
  task automatic tick();
    logic [63:0] expv;
    @(negedge clk);
    cyc++;
    rst_n = rstV; imem_gnt = gntV; inst_ready = readyV; flush = flushV; pc_i = pcReg;
    if (respEn && pendA.size() > 0 && pendC[0] < cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pendA[0]);
      void'(pendA.pop_front());
      void'(pendC.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (!rstV) sb.delete();
    else begin
      if (imem_req && imem_gnt) begin
        vectors++;
        if (imem_addr !== pc_i) begin
          miscompares++; $display("[TB] FAIL imem_addr: got %h expected %h", imem_addr, pc_i);
        end
        pendA.push_back(pc_i);
        pendC.push_back(cyc);
        sb.push_back({pc_i, memWord(pc_i)});
        if (autoPc) pcReg = pcReg + 32'd4;
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        pops++;
        if (sb.size() == 0) begin
          miscompares++; $display("[TB] FAIL unexpected_inst: got pc %h data %h expected none", inst_pc, inst_data);
        end else begin
          expv = sb.pop_front();
          if ({inst_pc, inst_data} !== expv) begin
            miscompares++;
            $display("[TB] FAIL inst_order: got pc %h data %h expected pc %h data %h",
                     inst_pc, inst_data, expv[63:32], expv[31:0]);
          end
        end
      end
      if (flushV) sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic g, input logic r, input logic f, input logic re);
    gntV = g; readyV = r; flushV = f; respEn = re;
  endtask

  task automatic drain(output bit done);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && (pendA.size() == 0);
    end
  endtask

  task automatic test_reset();
    rstV = 1'b0; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_stall: got %b expected 1", fetch_stall); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b expected 0", inst_valid); end
    vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d expected 0", ifq_count); end
    vectors++; if (inst_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_data: got %h expected 0", inst_data); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pc: got %h expected 0", inst_pc); end
    rstV = 1'b1;
    tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_stream();
    int p0; bit done;
    p0 = pops; pcReg = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (fetch_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_stall cycle %0d: got %b expected 0", i, fetch_stall); end
    end
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL stream_drain: got timeout expected empty"); end
    vectors++; if (pops - p0 < 6) begin miscompares++; $display("[TB] FAIL stream_pops: got %0d expected 6", pops - p0); end
  endtask

  task automatic test_full();
    int p0; bit done;
    pcReg = 32'h300;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    vectors++; if (ifq_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 4", ifq_count); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL full_req: got %b expected 0", imem_req); end
    vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL full_stall: got %b expected 1", fetch_stall); end
    vectors++; if (inst_pc !== 32'h300) begin miscompares++; $display("[TB] FAIL full_head: got %h expected 300", inst_pc); end
    p0 = pops;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) tick();
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL full_drain: got timeout expected empty"); end
    vectors++; if (pops - p0 < 5) begin miscompares++; $display("[TB] FAIL full_refill: got %0d pops expected >=5", pops - p0); end
  endtask

  task automatic test_gnt_stall();
    bit done;
    pcReg = 32'h10;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (fetch_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL gnt_stall %0d: got %b expected 1", i, fetch_stall); end
      vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL gnt_addr %0d: got %h expected 10", i, imem_addr); end
    end
    gntV = 1'b1; tick();
    vectors++; if (fetch_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL gnt_accept: got %b expected 0", fetch_stall); end
    gntV = 1'b0; tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL one_out_req: got %b expected 1", imem_req); end
    gntV = 1'b1; tick();
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL max_out_req: got %b expected 0", imem_req); end
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL gnt_drain: got timeout expected empty"); end
  endtask

  task automatic test_flush();
    int p0; bit done;
    pcReg = 32'h20;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    flushV = 1'b1; tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_req: got %b expected 0", imem_req); end
    flushV = 1'b0; respEn = 1'b1; pcReg = 32'h100; p0 = pops;
    tick();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid: got %b expected 0", inst_valid); end
    vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL flush_count: got %0d expected 0", ifq_count); end
    repeat (4) tick();
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL flush_drain: got timeout expected empty"); end
    vectors++; if (pops - p0 < 1) begin miscompares++; $display("[TB] FAIL flush_refetch: got %0d pops expected >=1", pops - p0); end
  endtask

  task automatic test_flush_rvalid();
    int p0; bit done;
    pcReg = 32'h20;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fr_flush_valid: got %b expected 0", inst_valid); end
    flushV = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fr_valid %0d: got %b expected 0", i, inst_valid); end
      vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL fr_count %0d: got %0d expected 0", i, ifq_count); end
    end
    pcReg = 32'h200; gntV = 1'b1; p0 = pops;
    repeat (3) tick();
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL fr_drain: got timeout expected empty"); end
    vectors++; if (pops - p0 < 2) begin miscompares++; $display("[TB] FAIL fr_refetch: got %0d pops expected >=2", pops - p0); end
  endtask

  task automatic test_reset_mid();
    bit done;
    pcReg = 32'h500;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    gntV = 1'b0; rstV = 1'b0; tick();
    rstV = 1'b1; respEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL late_rvalid_valid %0d: got %b expected 0", i, inst_valid); end
      vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL late_rvalid_count %0d: got %0d expected 0", i, ifq_count); end
    end
    pcReg = 32'h600; gntV = 1'b1;
    repeat (2) tick();
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL rstmid_drain: got timeout expected empty"); end
  endtask

  task automatic test_latency();
    bit done;
    pcReg = 32'h40;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
`ifdef IFQ_BYPASS_EN
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL byp_valid: got %b expected 1", inst_valid); end
    vectors++; if (inst_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL byp_data: got %h expected deadbeef", inst_data); end
    vectors++; if (inst_pc !== 32'h40) begin miscompares++; $display("[TB] FAIL byp_pc: got %h expected 40", inst_pc); end
    vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL byp_count: got %0d expected 0", ifq_count); end
    tick();
    vectors++; if (ifq_count !== 3'd0) begin miscompares++; $display("[TB] FAIL byp_count_after: got %0d expected 0", ifq_count); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL byp_valid_after: got %b expected 0", inst_valid); end
`else
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_valid0: got %b expected 0", inst_valid); end
    tick();
    vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_valid1: got %b expected 1", inst_valid); end
    vectors++; if (inst_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL lat_data: got %h expected deadbeef", inst_data); end
    vectors++; if (inst_pc !== 32'h40) begin miscompares++; $display("[TB] FAIL lat_pc: got %h expected 40", inst_pc); end
    vectors++; if (ifq_count !== 3'd1) begin miscompares++; $display("[TB] FAIL lat_count: got %0d expected 1", ifq_count); end
`endif
    drain(done);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL lat_drain: got timeout expected empty"); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    pc_i = '0; imem_rdata = '0;
    rstV = 1'b0; gntV = 1'b0; readyV = 1'b0; flushV = 1'b0; respEn = 1'b0; autoPc = 1'b1;
    pcReg = '0;
    test_reset();
    test_stream();
    test_full();
    test_gnt_stall();
    test_flush();
    test_flush_rvalid();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
